playback_voice_sched: RTL

//  Time-shares the single-port wav_bram read port among NUM_VOICES sample voices.
//  On each 44 kHz enable tick it sweeps all voices and fetches one sample per active voice.
//  It sums the fetched samples, saturates the sum to 16 bits and emits one mixed sample.

---
 rtl/playback_voice_sched_if.sv | 40 ++++
 rtl/playback_voice_sched.sv | 123 ++++++++++++
 2 files changed

// File: rtl/playback_voice_sched_if.sv
// Bundles the scheduler's trigger, BRAM and mixed-output signals.
// The slave modport is the scheduler; the master modport is the controller, BRAM and sink side.
interface playback_voice_sched_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_VOICES = 4,
    parameter int VID_W      = 2
);
    logic                    enable;
    logic                    trig_valid;
    logic [VID_W-1:0]        trig_voice;
    logic [ADDR_WIDTH-1:0]   trig_start;
    logic [ADDR_WIDTH-1:0]   trig_len;
    logic                    trig_loop;
    logic                    stop_all;
    logic [ADDR_WIDTH-1:0]   bram_addr;
    logic [15:0]             bram_dout;
    logic signed [15:0]      data_out;
    logic                    valid_out;
    logic [NUM_VOICES-1:0]   voice_active;
    logic                    busy;
    logic                    overrun;
    logic [1:0]              state_dbg;

    // Triggers are single-cycle commands with no back-pressure: trig_valid is
    // acted on in the cycle it is high. valid_out is a one-cycle strobe with no
    // ready; the sink must take data_out in that cycle.
    modport slave (
        input  enable, trig_valid, trig_voice, trig_start, trig_len, trig_loop,
               stop_all, bram_dout,
        output bram_addr, data_out, valid_out, voice_active, busy, overrun,
               state_dbg
    );

    modport master (
        output enable, trig_valid, trig_voice, trig_start, trig_len, trig_loop,
               stop_all, bram_dout,
        input  bram_addr, data_out, valid_out, voice_active, busy, overrun,
               state_dbg
    );
endinterface

// File: rtl/playback_voice_sched.sv
// Sweeps all voices on each sample tick, reading one sample per active voice from
// a single-port BRAM, and emits the 16-bit saturated sum of those samples.
module playback_voice_sched #(
    parameter int MEM_DEPTH  = 44000,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int NUM_VOICES = 4,
    parameter int VID_W      = $clog2(NUM_VOICES)
) (
    input logic                   clk,
    input logic                   rst,
    playback_voice_sched_if.slave io
);
    localparam int ACC_W = 16 + VID_W;
    localparam logic [VID_W-1:0]    LAST_VID = VID_W'(NUM_VOICES - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_X  = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CAPT = 2'd2, MIX = 2'd3} state_t;

    state_t                  state, state_nxt;
    logic [VID_W-1:0]        vid;
    logic [ACC_W-1:0]        acc;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   base_q [NUM_VOICES];
    logic [ADDR_WIDTH-1:0]   len_q  [NUM_VOICES];
    logic [ADDR_WIDTH-1:0]   pos_q  [NUM_VOICES];
    logic [NUM_VOICES-1:0]   loop_q;
    logic [NUM_VOICES-1:0]   active_q;
    logic [ADDR_WIDTH:0]     addr_sum;
    logic [ADDR_WIDTH:0]     addr_wrap;
    logic                    pos_ovf, neg_ovf;
    logic [15:0]             sat;
    logic                    trig_load;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (io.enable) state_nxt = ISSUE;
            ISSUE:   state_nxt = CAPT;
            CAPT:    state_nxt = (vid == LAST_VID) ? MIX : ISSUE;
            MIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Clip addresses wrap around the end of the BRAM rather than overflowing the bus.
    assign addr_sum  = {1'b0, base_q[vid]} + {1'b0, pos_q[vid]};
    assign addr_wrap = (addr_sum >= DEPTH_X) ? (addr_sum - DEPTH_X) : addr_sum;
    assign io.bram_addr = (state == ISSUE) ? addr_wrap[ADDR_WIDTH-1:0] : addr_q;

    assign pos_ovf = !acc[ACC_W-1] && (|acc[ACC_W-2:15]);
    assign neg_ovf =  acc[ACC_W-1] && !(&acc[ACC_W-2:15]);
    assign sat     = pos_ovf ? 16'h7fff : (neg_ovf ? 16'h8000 : acc[15:0]);

    assign trig_load = io.trig_valid && (io.trig_len != '0) && !io.stop_all;

    always_ff @(posedge clk) begin
        if (rst) begin
            vid         <= '0;
            acc         <= '0;
            addr_q      <= '0;
            loop_q      <= '0;
            active_q    <= '0;
            io.data_out <= '0;
            io.valid_out <= 1'b0;
            io.overrun  <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                base_q[i] <= '0;
                len_q[i]  <= '0;
                pos_q[i]  <= '0;
            end
        end else begin
            io.valid_out <= 1'b0;
            addr_q       <= io.bram_addr;
            if (io.enable && (state != IDLE)) io.overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (io.enable) begin
                        acc <= '0;
                        vid <= '0;
                    end
                end
                CAPT: begin
                    vid <= vid + VID_W'(1);
                    if (active_q[vid]) begin
                        acc <= acc + {{VID_W{io.bram_dout[15]}}, io.bram_dout};
                        if (pos_q[vid] == len_q[vid] - ADDR_WIDTH'(1)) begin
                            pos_q[vid]    <= '0;
                            active_q[vid] <= loop_q[vid];
                        end else begin
                            pos_q[vid] <= pos_q[vid] + ADDR_WIDTH'(1);
                        end
                    end
                end
                MIX: begin
                    io.data_out  <= sat;
                    io.valid_out <= 1'b1;
                end
                default: ;
            endcase

            // Later assignments win: a trigger overrides the sweep's update of the
            // same voice, and stop_all overrides both.
            if (trig_load) begin
                base_q[io.trig_voice]   <= io.trig_start;
                len_q[io.trig_voice]    <= io.trig_len;
                pos_q[io.trig_voice]    <= '0;
                loop_q[io.trig_voice]   <= io.trig_loop;
                active_q[io.trig_voice] <= 1'b1;
            end
            if (io.stop_all) active_q <= '0;
        end
    end

    assign io.voice_active = active_q;
    assign io.busy         = (state != IDLE);
    assign io.state_dbg    = state;
endmodule
